// File: rtl/axi_lite_cmd_queue.sv
// Command queue in front of the AXI4-Lite master: buffers read/write commands,
// issues them one at a time as strobes, waits for completion or timeout, returns one response each.
module axi_lite_cmd_queue #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDR_W-1:0]        cmd_addr,
    input  logic [DATA_W-1:0]        cmd_wdata,
    output logic                     wr_en,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        addr,
    output logic [DATA_W-1:0]        wdata_in,
    input  logic [DATA_W-1:0]        rdata_out,
    input  logic                     write_done,
    input  logic                     read_done,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_write,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    logic              mem_write_q [DEPTH];
    logic [ADDR_W-1:0] mem_addr_q  [DEPTH];
    logic [DATA_W-1:0] mem_wdata_q [DEPTH];

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    state_e            state_q;
    logic              op_write_q;
    logic [TW-1:0]     timer_q;
    logic              wdone_q, rdone_q;
    logic              wr_en_q, rd_en_q, rsp_valid_q, rsp_write_q, rsp_err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rsp_rdata_q;
    logic              push, pop, done_edge;

    assign cmd_ready = (count_q != CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == S_IDLE) && (count_q != '0) && !rsp_valid_q;
    // Only a fresh rising edge of the active op's done counts; a level left high is stale.
    assign done_edge = op_write_q ? (write_done && !wdone_q) : (read_done && !rdone_q);

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: storage array is deliberately not reset; occupancy is tracked by pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_write_q[wr_ptr_q] <= cmd_write;
            mem_addr_q[wr_ptr_q]  <= cmd_addr;
            mem_wdata_q[wr_ptr_q] <= cmd_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            op_write_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            timer_q     <= '0;
            wdone_q     <= 1'b0;
            rdone_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            wdone_q <= write_done;
            rdone_q <= read_done;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        op_write_q <= mem_write_q[rd_ptr_q];
                        addr_q     <= mem_addr_q[rd_ptr_q];
                        wdata_q    <= mem_wdata_q[rd_ptr_q];
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wr_en_q <= op_write_q;
                    rd_en_q <= !op_write_q;
                    timer_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (done_edge) begin
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= op_write_q;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= op_write_q ? '0 : rdata_out;
                        state_q     <= S_RESP;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= op_write_q;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        state_q     <= S_RESP;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wr_en     = wr_en_q;
    assign rd_en     = rd_en_q;
    assign addr      = addr_q;
    assign wdata_in  = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign count     = count_q;
endmodule

// File: tb/tb_axi_lite_cmd_queue.sv
// Directed bench for axi_lite_cmd_queue: hand-computed expectations, sampled on the falling edge.
module tb_axi_lite_cmd_queue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic        cmd_ready, wr_en, rd_en;
    logic [31:0] addr, wdata_in;
    logic [31:0] rdata_out = '0;
    logic        write_done = 1'b0, read_done = 1'b0;
    logic        rsp_valid, rsp_write, rsp_err;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_lite_cmd_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT(64)) dut (
        .clk(clk), .reset(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata_in(wdata_in),
        .rdata_out(rdata_out), .write_done(write_done), .read_done(read_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .count(count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        check({tag, "_count"},     count, 3'd0);
        check({tag, "_wr_en"},     wr_en, 1'b0);
        check({tag, "_rd_en"},     rd_en, 1'b0);
        check({tag, "_addr"},      addr, 32'h0);
        check({tag, "_wdata"},     wdata_in, 32'h0);
        check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        check({tag, "_rsp_write"}, rsp_write, 1'b0);
        check({tag, "_rsp_err"},   rsp_err, 1'b0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    endtask

    task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
        check("push_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Returns on the falling edge where a strobe is visible (first cycle of WAIT).
    task automatic wait_strobe();
        int n = 0;
        while (!(wr_en || rd_en) && n < 20) begin
            tick();
            n++;
        end
        check("strobe_seen", wr_en | rd_en, 1'b1);
    endtask

    task automatic serve(input logic w, input logic [31:0] a, input logic [31:0] d);
        wait_strobe();
        check("srv_wr_en", wr_en, w);
        check("srv_rd_en", rd_en, !w);
        check("srv_addr", addr, a);
        if (w) check("srv_wdata", wdata_in, d);
        if (w) write_done = 1'b1;
        else begin
            read_done = 1'b1;
            rdata_out = d;
        end
        tick();
        write_done = 1'b0; read_done = 1'b0; rdata_out = '0;
        check("srv_rsp_valid", rsp_valid, 1'b1);
        check("srv_rsp_write", rsp_write, w);
        check("srv_rsp_rdata", rsp_rdata, w ? 32'h0 : d);
        check("srv_rsp_err", rsp_err, 1'b0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("srv_rsp_drop", rsp_valid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;

        // Reset state
        repeat (3) tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick();

        // Single write: push at N, latch at N+1, strobe visible after N+2 for one cycle
        push_cmd(1'b1, 32'h0000_0010, 32'hCEEB_2006);
        check("w1_count_after_push", count, 3'd1);
        check("w1_no_early_strobe", wr_en, 1'b0);
        tick();
        check("w1_latched_addr", addr, 32'h10);
        check("w1_latched_wdata", wdata_in, 32'hCEEB_2006);
        check("w1_count_after_pop", count, 3'd0);
        check("w1_strobe_not_yet", wr_en, 1'b0);
        tick();
        check("w1_wr_en", wr_en, 1'b1);
        check("w1_rd_en", rd_en, 1'b0);
        tick();
        check("w1_wr_en_width", wr_en, 1'b0);
        check("w1_rsp_before_done", rsp_valid, 1'b0);
        write_done = 1'b1;
        tick();
        write_done = 1'b0;
        check("w1_rsp_valid", rsp_valid, 1'b1);
        check("w1_rsp_write", rsp_write, 1'b1);
        check("w1_rsp_err", rsp_err, 1'b0);
        check("w1_rsp_rdata", rsp_rdata, 32'h0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("w1_rsp_drop", rsp_valid, 1'b0);

        // Write then read: read is not issued until the write response is accepted
        push_cmd(1'b1, 32'h0000_0010, 32'hCEEB_2006);
        push_cmd(1'b0, 32'h0000_0010, 32'h0);
        check("wr_count_push_pop", count, 3'd1);
        tick();
        check("wr_wr_en", wr_en, 1'b1);
        write_done = 1'b1;
        tick();
        write_done = 1'b0;
        check("wr_rsp1_valid", rsp_valid, 1'b1);
        check("wr_rsp1_write", rsp_write, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            seen = seen | rd_en;
            tick();
        end
        check("wr_rd_blocked", seen | rd_en, 1'b0);
        check("wr_rsp1_held", rsp_valid, 1'b1);
        check("wr_count_held", count, 3'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("wr_rsp1_drop", rsp_valid, 1'b0);
        tick();
        check("wr_rd_not_yet", rd_en, 1'b0);
        tick();
        check("wr_rd_en", rd_en, 1'b1);
        check("wr_rd_addr", addr, 32'h10);
        read_done = 1'b1; rdata_out = 32'hCEEB_2006;
        tick();
        read_done = 1'b0; rdata_out = '0;
        check("wr_rsp2_valid", rsp_valid, 1'b1);
        check("wr_rsp2_write", rsp_write, 1'b0);
        check("wr_rsp2_rdata", rsp_rdata, 32'hCEEB_2006);
        check("wr_rsp2_err", rsp_err, 1'b0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // FIFO full: an unaccepted response blocks issue while the FIFO fills
        push_cmd(1'b0, 32'h0000_0020, 32'h0);
        wait_strobe();
        read_done = 1'b1; rdata_out = 32'h1111_2222;
        tick();
        read_done = 1'b0; rdata_out = '0;
        check("full_pre_rsp", rsp_valid, 1'b1);
        check("full_pre_rdata", rsp_rdata, 32'h1111_2222);
        push_cmd(1'b1, 32'h0000_0100, 32'hA000_0000);
        push_cmd(1'b0, 32'h0000_0104, 32'h0);
        push_cmd(1'b1, 32'h0000_0108, 32'hA000_0002);
        push_cmd(1'b0, 32'h0000_010C, 32'h0);
        check("full_count4", count, 3'd4);
        check("full_cmd_ready_low", cmd_ready, 1'b0);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0110; cmd_wdata = 32'hA000_0004;
        tick();
        check("full_5th_stalled", count, 3'd4);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("full_handshake", rsp_valid, 1'b0);
        check("full_count_at_hs", count, 3'd4);
        tick();
        check("full_count_after_pop", count, 3'd3);
        check("full_cmd_ready_back", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        check("full_5th_accepted", count, 3'd4);
        serve(1'b1, 32'h0000_0100, 32'hA000_0000);
        serve(1'b0, 32'h0000_0104, 32'hB000_0001);
        serve(1'b1, 32'h0000_0108, 32'hA000_0002);
        serve(1'b0, 32'h0000_010C, 32'hB000_0003);
        serve(1'b1, 32'h0000_0110, 32'hA000_0004);
        check("full_drained", count, 3'd0);

        // Stale done: a held write_done level never completes a later write
        push_cmd(1'b1, 32'h0000_0030, 32'hA5A5_0001);
        wait_strobe();
        write_done = 1'b1;
        tick();
        check("stale_first_done", rsp_valid, 1'b1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        push_cmd(1'b1, 32'h0000_0034, 32'hA5A5_0002);
        wait_strobe();
        repeat (5) tick();
        check("stale_no_completion", rsp_valid, 1'b0);
        write_done = 1'b0;
        tick();
        check("stale_low_no_rsp", rsp_valid, 1'b0);
        write_done = 1'b1;
        tick();
        check("stale_new_edge_rsp", rsp_valid, 1'b1);
        check("stale_new_edge_err", rsp_err, 1'b0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        push_cmd(1'b1, 32'h0000_0038, 32'hA5A5_0003);
        wait_strobe();
        repeat (63) tick();
        check("stale_to_not_early", rsp_valid, 1'b0);
        tick();
        check("stale_to_valid", rsp_valid, 1'b1);
        check("stale_to_err", rsp_err, 1'b1);
        check("stale_to_write", rsp_write, 1'b1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        write_done = 1'b0;

        // Read timeout: the write done pulse and nonzero rdata_out must be ignored
        push_cmd(1'b0, 32'h0000_0040, 32'h0);
        rdata_out = 32'hDEAD_BEEF;
        wait_strobe();
        repeat (10) tick();
        write_done = 1'b1;
        tick();
        write_done = 1'b0;
        repeat (52) tick();
        check("to_not_early", rsp_valid, 1'b0);
        tick();
        check("to_valid", rsp_valid, 1'b1);
        check("to_err", rsp_err, 1'b1);
        check("to_rdata_zero", rsp_rdata, 32'h0);
        check("to_write", rsp_write, 1'b0);
        rdata_out = '0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Reset mid-WAIT with two commands queued
        push_cmd(1'b1, 32'h0000_0050, 32'h5050_5050);
        wait_strobe();
        push_cmd(1'b0, 32'h0000_0054, 32'h0);
        push_cmd(1'b1, 32'h0000_0058, 32'h5858_5858);
        check("mid_count2", count, 3'd2);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid");
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            write_done = (i == 2);
            seen = seen | rsp_valid | wr_en | rd_en;
            tick();
        end
        write_done = 1'b0;
        check("mid_no_activity", seen | rsp_valid, 1'b0);
        check("mid_count_zero", count, 3'd0);

        // Recovery after reset
        push_cmd(1'b1, 32'h0000_0060, 32'h600D_F00D);
        serve(1'b1, 32'h0000_0060, 32'h600D_F00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_lite_cmd_queue.md
# axi_lite_cmd_queue

Command front-end that sits directly upstream of the AXI4-Lite `top` block. It buffers read/write requests in a small FIFO and issues them one at a time on `top`'s pulse-style `wr_en`/`rd_en` interface. It waits for the matching `write_done`/`read_done`, applies a timeout, and returns one response per command over a valid/ready channel.

## Interface
Parameters:
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 64: max cycles in WAIT before an error response; ≥2.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `cmd_valid`  in  1  upstream command present.
- `cmd_ready`  out  1  FIFO can accept (`count != DEPTH`).
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_W  command address.
- `cmd_wdata`  in  DATA_W  write data; ignored for reads.
- `wr_en`  out  1  one-cycle write strobe to `top`.
- `rd_en`  out  1  one-cycle read strobe to `top`.
- `addr`  out  ADDR_W  address to `top`.
- `wdata_in`  out  DATA_W  write data to `top`.
- `rdata_out`  in  DATA_W  read data from `top`.
- `write_done`  in  1  write completion from `top`.
- `read_done`  in  1  read completion from `top`.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  response consumer accepts.
- `rsp_write`  out  1  response belongs to a write.
- `rsp_rdata`  out  DATA_W  read data; 0 for writes and errors.
- `rsp_err`  out  1  timeout occurred.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- **FIFO**
  - Push on `cmd_valid & cmd_ready`.
  - Pop when the FSM leaves IDLE.
  - Simultaneous push and pop: `count` is unchanged and both happen.
  - Pointers wrap modulo DEPTH.
- **FSM states and transitions**
  - IDLE: when `count != 0` and `rsp_valid == 0`, pop the head, latch it into the `addr`/`wdata_in`/op registers, and go to ISSUE.
  - ISSUE: assert `wr_en` or `rd_en` for exactly this cycle, clear the timer, and go to WAIT.
  - WAIT: done-edge detection.
    - Completion is a rising edge of the op's done signal: `done & ~done_q`, where `done_q` is the registered done.
    - The other op's done is ignored.
    - On completion, capture `rdata_out` for reads (0 for writes), set `rsp_err=0`, and go to RESP.
    - If the timer reaches `TIMEOUT-1` without completion, set `rsp_err=1`, `rsp_rdata=0`, and go to RESP.
  - RESP: hold `rsp_valid=1` until `rsp_ready`, then go to IDLE.
- `addr` and `wdata_in` stay stable from ISSUE until the next command is latched.
- A response that has not been accepted blocks the next issue; the FIFO continues to accept commands.
- **Reset** (any time, including mid-transaction):
  - FIFO empty, `count=0`, FSM to IDLE.
  - `cmd_ready=1`, `wr_en=rd_en=0`, `addr=wdata_in=0`.
  - `rsp_valid=rsp_write=rsp_err=0`, `rsp_rdata=0`, `done_q=0`.
  - An in-flight transaction is abandoned; no response is produced for it.

## Timing
- Command pushed into an empty FIFO while the FSM is in IDLE: latched the cycle after push, strobe the cycle after that.
  - Push at edge N, strobe high during cycle N+2.
- Strobe width is exactly 1 cycle.
- `rsp_valid` rises the cycle after the completion edge is sampled.
- Back-to-back commands: the next strobe comes ≥2 cycles after the response handshake (IDLE, then ISSUE).
- Timeout: `rsp_err` response after exactly TIMEOUT cycles in WAIT.
- All outputs are registered except `cmd_ready`, which is derived combinationally from `count`.

## Test plan
- **Single write.** Push write 0x00000010 / 0xCEEB2006.
  - `wr_en` pulses 1 cycle with `addr=0x10`, `wdata_in=0xCEEB2006`.
  - After a `write_done` rising edge: `rsp_valid=1`, `rsp_write=1`, `rsp_err=0`, `rsp_rdata=0`.
- **Write then read.** Write as above, then read 0x10 with the model returning 0xCEEB2006.
  - Response order is write then read.
  - Read response has `rsp_rdata=0xCEEB2006`.
  - `rd_en` does not pulse until the write response has been accepted.
- **FIFO full.** Push 5 commands with DEPTH=4 while `rsp_ready=0`.
  - `cmd_ready` drops once `count=4`.
  - The 5th command is accepted only after the first response handshake.
  - Pointers wrap; all 5 responses arrive in order.
- **Stale done.** Hold `write_done=1` high continuously, then issue a second write.
  - No completion until `write_done` falls and rises again.
  - With no new edge: timeout with `rsp_err=1` after TIMEOUT cycles.
- **Timeout.** Read with no `read_done`, TIMEOUT=64.
  - `rsp_valid` with `rsp_err=1` and `rsp_rdata=0` exactly 64 cycles after entering WAIT.
- **Reset mid-WAIT.** Assert `reset=0` while in WAIT with 2 commands queued.
  - All outputs go to their reset values asynchronously; `count=0`.
  - After release, no response is produced for the abandoned commands.
